rempty_rptr_fwft_fifo: RTL
==========================

Name: rempty_rptr_fwft_fifo

Overview:
- Read-side control for the team's async FIFO: read binary/Gray pointers, registered empty flag, and a first-word-fall-through (FWFT) output register with a valid/ready handshake to the consumer.
- Sits in the consumer clock domain, opposite the write-side full/pointer logic.
- Takes the write Gray pointer already 2-flop synchronized into this domain. Drives the RAM read address and the Gray read pointer back to the write-side synchronizer.

Parameters:
ADDRSIZE, 4, FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
DATASIZE, 8, data word width
AEMPTY_THRESH, 2, almost-empty threshold in words (used only with the optional feature)

Ports:
wclk  input  1  clock
wrst  input  1  reset, asynchronous, active-high
rq2_wptr  input  ADDRSIZE+1  write Gray pointer, synchronized into this domain
rdata_mem  input  DATASIZE  RAM read data; combinational function of raddr
raddr  output  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0]
rptr  output  ADDRSIZE+1  registered Gray read pointer
rempty  output  1  RAM holds no unread word (excludes the output register)
dout  output  DATASIZE  FWFT output data
dout_valid  output  1  dout holds a valid word
dout_ready  input  1  consumer accepts dout this cycle
aempty  output  1  almost-empty (see Optional Feature)

Behaviour:
- Reset values (async on wrst): rbin=0, rptr=0, rempty=1, dout=0, dout_valid=0, aempty=1. Any buffered word is discarded; wrst must reset the write side too.
- Internal pop: pop = ~rempty & (~dout_valid | dout_ready).
- Pointer arithmetic:
  - rbinnext = rbin + pop, modulo 2**(ADDRSIZE+1), natural wrap.
  - rgraynext = rbinnext ^ (rbinnext >> 1).
  - Each edge: {rbin, rptr} <= {rbinnext, rgraynext}.
- Empty flag: each edge, rempty <= (rgraynext == rq2_wptr). Registered; no combinational path from rq2_wptr to outputs.
- Output register:
  - pop=1: dout <= rdata_mem (word at the current raddr); dout_valid <= 1.
  - pop=0 and dout_ready=1: dout_valid <= 0, dout unchanged.
  - Otherwise: hold.
- Handshake:
  - A transfer occurs on an edge where dout_valid & dout_ready.
  - While dout_valid & ~dout_ready, dout and raddr are stable and no pop occurs.
  - dout_ready is allowed while dout_valid=0 and has no effect.
- Throughput: with dout_ready held at 1 and data available, one word per cycle, no bubbles.
- Simultaneous transfer + pop: dout is replaced by the next word in the same edge; dout_valid stays 1.
- Latency from rq2_wptr change (FIFO was empty): rempty falls at edge 1, dout_valid rises at edge 2.
- Wrap-around:
  - raddr wraps 2**ADDRSIZE-1 -> 0.
  - The pointer MSB toggles every 2**ADDRSIZE words, so Gray compare distinguishes full from empty on the write side.
- rq2_wptr is assumed Gray-coded; in-transit single-bit changes only delay rempty deassertion and never cause a false not-empty.

Optional Feature:
- Macro: RFIFO_ALMOST_EMPTY_EN.
- Defined:
  - Convert rq2_wptr Gray to binary (wbin_s).
  - Level = wbin_s - rbinnext, ADDRSIZE+1 bits, modulo.
  - Each edge: aempty <= (level <= AEMPTY_THRESH). Reset value 1.
- Not defined: aempty = rempty (combinational tie); no Gray-to-binary logic is synthesized.

Test Plan:
- Reset: wrst=1 mid-run with dout_valid=1 -> immediately rptr=0, raddr=0, rempty=1, dout_valid=0, dout=0, aempty=1.
- Single word: mem[0]=0xA5, rq2_wptr 00000->00001, dout_ready=0 -> rempty=0 after edge 1. After edge 2: dout=0xA5, dout_valid=1, raddr=1, rptr=00001, rempty=1. dout_valid drops one edge after dout_ready=1.
- Backpressure: mem[1..3]=0x11,0x22,0x33, rq2_wptr=gray(4)=00110, dout_ready=0 -> dout holds 0xA5, raddr holds 1. Raise dout_ready -> dout = 0x11, 0x22, 0x33 on consecutive edges, then dout_valid=0, rempty=1.
- Wrap: stream 40 words with dout_ready=1 -> raddr sequence 0..15,0..15,0..7. rptr=10000 at rbin=31, then 00000 at rbin=32. All 40 data words match in order.
- Simultaneous: dout_valid=1, dout_ready=1, rempty=0 on the same edge -> new word loaded, dout_valid stays 1, no dropped or duplicated word.
- Almost-empty (macro defined, AEMPTY_THRESH=2): level 3 -> aempty=0; after one pop (level 2) -> aempty=1 on that edge. Macro undefined -> aempty tracks rempty exactly.

Source files
------------

// File: rtl/rempty_rptr_fwft_fifo.sv
// Read-side control for the async FIFO: binary/Gray read pointers, registered empty flag and a
// first-word-fall-through output register. Define RFIFO_ALMOST_EMPTY_EN for a registered almost-empty flag.
module rempty_rptr_fwft_fifo #(
  parameter int ADDRSIZE      = 4,
  parameter int DATASIZE      = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                aempty
);

  logic [ADDRSIZE:0]   rbin_q, rbin_d;
  logic [ADDRSIZE:0]   rptr_q, rgray_d;
  logic                rempty_q, rempty_d;
  logic [DATASIZE-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                pop;

  // A RAM word moves into the output register whenever that register is free or being drained
  always_comb begin
    pop          = ~rempty_q & (~dout_valid_q | dout_ready);
    rbin_d       = rbin_q + (ADDRSIZE+1)'(pop);
    rgray_d      = rbin_d ^ (rbin_d >> 1);
    rempty_d     = (rgray_d == rq2_wptr);
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (pop) begin
      dout_d       = rdata_mem;
      dout_valid_d = 1'b1;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // Stage p0: pointers, empty flag and output register
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rgray_d;
      rempty_q     <= rempty_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef RFIFO_ALMOST_EMPTY_EN
  localparam logic [ADDRSIZE:0] AE_TH = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] level;
  logic              aempty_q, aempty_d;

  // Level is measured against the post-pop pointer so the flag lines up with rempty
  always_comb begin
    wbin_s           = '0;
    wbin_s[ADDRSIZE] = rq2_wptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
    end
    level    = wbin_s - rbin_d;
    aempty_d = (level <= AE_TH);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      aempty_q <= 1'b1;
    end else begin
      aempty_q <= aempty_d;
    end
  end

  assign aempty = aempty_q;
`else
  assign aempty = rempty_q;
`endif

endmodule
